// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder -> 4-bit drive code; latency 2 clk after synced final edge (+2 sync), no backpressure.
// Optional IR_HOLD_TIMEOUT_EN forces STOP after HOLD_MS ms without an accepted frame or repeat.
module ir_nec_decoder #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter logic [7:0]  EXPECT_ADDR = 8'h00,
  parameter bit          ADDR_CHECK  = 1'b1,
  parameter int unsigned HOLD_MS     = 150,
  // microseconds represented by one tick; >1 lets a slow clock still measure real-time widths
  parameter int unsigned TICK_US     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir_in,
  output logic [3:0] state_control,
  output logic [7:0] cmd,
  output logic [7:0] addr,
  output logic       cmd_valid,
  output logic       repeat_pulse,
  output logic       frame_err,
  output logic       busy
);

  localparam longint unsigned DIV_CALC = (64'(CLK_FREQ_HZ) * 64'(TICK_US)) / 64'd1_000_000;
  localparam int unsigned TICK_DIV = (DIV_CALC == 0) ? 1 : 32'(DIV_CALC);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [15:0] STEP = 16'(TICK_US);

  if (HOLD_MS == 0 || HOLD_MS > 65535 || TICK_US == 0 || TICK_US >= 1000) begin : g_param_range
    $error("ir_nec_decoder: HOLD_MS or TICK_US out of range");
  end

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, RPT_MARK, CHECK
  } state_t;

  state_t      state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic        tick;
  logic        ir_s1, ir_s2, ir_d;
  logic        fall, rise, edge_det;
  logic [15:0] width;
  logic [4:0]  bit_cnt;
  logic [31:0] shift;
  logic        frame_seen;
  logic        err_nxt, rpt_nxt, acc_nxt;
  logic        shift_en, shift_bit, bits_clr, timeout;
  logic [7:0]  fa, fa_n, fc, fc_n;
  logic        frame_ok;
  logic [4:0]  map_res;
  logic        hold_expire;

  function automatic logic in_rng(input logic [15:0] w, input logic [15:0] lo, input logic [15:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  // {hit, code}; unmapped commands leave the drive state alone
  function automatic logic [4:0] map_cmd(input logic [7:0] c);
    case (c)
      8'h1C:   return 5'b1_0000;
      8'h08:   return 5'b1_0001;
      8'h5A:   return 5'b1_0010;
      8'h45:   return 5'b1_0011;
      8'h18:   return 5'b1_0100;
      8'h47:   return 5'b1_0101;
      8'h52:   return 5'b1_0110;
      8'h0C:   return 5'b1_0111;
      8'h5E:   return 5'b1_1000;
      default: return 5'b0_0000;
    endcase
  endfunction

  assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_s1 <= 1'b1;
      ir_s2 <= 1'b1;
      ir_d  <= 1'b1;
    end else begin
      ir_s1 <= ir_in;
      ir_s2 <= ir_s1;
      ir_d  <= ir_s2;
    end
  end

  assign fall     = ir_d & ~ir_s2;
  assign rise     = ~ir_d & ir_s2;
  assign edge_det = fall | rise;

  // width at an edge is the length of the phase that just ended
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      width <= '0;
    end else if (edge_det) begin
      width <= '0;
    end else if (tick) begin
      width <= (width > 16'hFFFF - STEP) ? 16'hFFFF : width + STEP;
    end
  end

  assign fa       = shift[7:0];
  assign fa_n     = shift[15:8];
  assign fc       = shift[23:16];
  assign fc_n     = shift[31:24];
  assign frame_ok = ((fa ^ fa_n) == 8'hFF) && ((fc ^ fc_n) == 8'hFF) &&
                    (!ADDR_CHECK || (fa == EXPECT_ADDR));
  assign map_res  = map_cmd(fc);
  assign timeout  = (width > 16'd12000) && !edge_det;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    rpt_nxt   = 1'b0;
    acc_nxt   = 1'b0;
    shift_en  = 1'b0;
    shift_bit = 1'b0;
    bits_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (fall) state_nxt = LEAD_MARK;
      end
      LEAD_MARK: begin
        if (rise) begin
          if (in_rng(width, 16'd8000, 16'd10000)) begin
            state_nxt = LEAD_SPACE;
          end else begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end
        end
      end
      LEAD_SPACE: begin
        if (fall) begin
          if (in_rng(width, 16'd4000, 16'd5000)) begin
            state_nxt = BIT_MARK;
            bits_clr  = 1'b1;
          end else if (in_rng(width, 16'd2000, 16'd2500)) begin
            state_nxt = RPT_MARK;
          end else begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end
        end
      end
      BIT_MARK: begin
        if (rise) begin
          if (in_rng(width, 16'd400, 16'd700)) begin
            state_nxt = BIT_SPACE;
          end else begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end
        end
      end
      BIT_SPACE: begin
        if (fall) begin
          if (in_rng(width, 16'd400, 16'd700) || in_rng(width, 16'd1400, 16'd1900)) begin
            shift_en  = 1'b1;
            shift_bit = in_rng(width, 16'd1400, 16'd1900);
            state_nxt = (bit_cnt == 5'd31) ? CHECK : BIT_MARK;
          end else begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end
        end
      end
      RPT_MARK: begin
        if (rise) begin
          state_nxt = IDLE;
          if (in_rng(width, 16'd400, 16'd700)) begin
            rpt_nxt = frame_seen;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      CHECK: begin
        state_nxt = IDLE;
        if (frame_ok) begin
          acc_nxt = 1'b1;
        end else begin
          err_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // a stalled phase aborts once; IDLE never times out so the strobe cannot repeat
    if (state != IDLE && state != CHECK && timeout) begin
      state_nxt = IDLE;
      err_nxt   = 1'b1;
      rpt_nxt   = 1'b0;
      shift_en  = 1'b0;
      bits_clr  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt       <= '0;
      shift         <= '0;
      frame_seen    <= 1'b0;
      cmd           <= '0;
      addr          <= '0;
      state_control <= 4'b0000;
      cmd_valid     <= 1'b0;
      repeat_pulse  <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      cmd_valid    <= acc_nxt;
      repeat_pulse <= rpt_nxt;
      frame_err    <= err_nxt;
      if (bits_clr) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (shift_en) begin
        shift <= {shift_bit, shift[31:1]};
      end
      if (acc_nxt) begin
        cmd        <= fc;
        addr       <= fa;
        frame_seen <= 1'b1;
        if (map_res[4]) state_control <= map_res[3:0];
      end else if (hold_expire) begin
        state_control <= 4'b0000;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef IR_HOLD_TIMEOUT_EN
  localparam logic [15:0] HOLD_LIM = 16'(HOLD_MS);
  logic [15:0] us_acc;
  logic [15:0] ms_cnt;
  logic        hold_active;
  logic        us_wrap;
  logic        restart;

  assign restart     = cmd_valid | repeat_pulse;
  assign us_wrap     = (us_acc + STEP) >= 16'd1000;
  assign hold_expire = hold_active && tick && us_wrap && !restart &&
                       (ms_cnt == HOLD_LIM - 16'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      us_acc      <= '0;
      ms_cnt      <= '0;
      hold_active <= 1'b0;
    end else if (restart) begin
      us_acc      <= '0;
      ms_cnt      <= '0;
      hold_active <= 1'b1;
    end else if (hold_active && tick) begin
      if (us_wrap) begin
        us_acc <= us_acc + STEP - 16'd1000;
        if (hold_expire) begin
          hold_active <= 1'b0;
        end else begin
          ms_cnt <= ms_cnt + 16'd1;
        end
      end else begin
        us_acc <= us_acc + STEP;
      end
    end
  end
`else
  assign hold_expire = 1'b0;
`endif

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed + randomized NEC frames against a byte-level reference model; 1 clock = 20 us of IR time.
module tb_ir_nec_decoder;
  localparam int US_PER_CLK = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ir_in = 1'b1;
  logic [3:0] state_control;
  logic [7:0] cmd, addr;
  logic       cmd_valid, repeat_pulse, frame_err, busy;

  int errors = 0, checks = 0;
  int n_vld = 0, n_rpt = 0, n_err = 0, n_multi = 0;
  int e_vld = 0, e_rpt = 0, e_err = 0;
  logic [3:0] m_sc = 4'b0000;
  logic [7:0] m_cmd = 8'h00, m_addr = 8'h00;
  bit         m_seen = 1'b0;
  // drive code for a command is its position in this list
  logic [7:0] keys [9] = '{8'h1C, 8'h08, 8'h5A, 8'h45, 8'h18, 8'h47, 8'h52, 8'h0C, 8'h5E};

  always #5 clk = ~clk;

  ir_nec_decoder #(
    .CLK_FREQ_HZ(50_000), .EXPECT_ADDR(8'h00), .ADDR_CHECK(1'b1),
    .HOLD_MS(150), .TICK_US(20)
  ) dut (
    .clk(clk), .rst(rst), .ir_in(ir_in), .state_control(state_control),
    .cmd(cmd), .addr(addr), .cmd_valid(cmd_valid), .repeat_pulse(repeat_pulse),
    .frame_err(frame_err), .busy(busy)
  );

  always begin
    @(posedge clk);
    #1;
    if (cmd_valid) n_vld++;
    if (repeat_pulse) n_rpt++;
    if (frame_err) n_err++;
    if (int'(cmd_valid) + int'(repeat_pulse) + int'(frame_err) > 1) n_multi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " cmd_valid count"}, n_vld, e_vld);
    check({tag, " repeat count"}, n_rpt, e_rpt);
    check({tag, " frame_err count"}, n_err, e_err);
    check({tag, " state_control"}, state_control, m_sc);
    check({tag, " cmd"}, cmd, m_cmd);
    check({tag, " addr"}, addr, m_addr);
    check({tag, " busy"}, busy, 1'b0);
  endtask

  task automatic hold_lvl(input logic lvl, input int us);
    ir_in = lvl;
    repeat (us / US_PER_CLK) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits);
    hold_lvl(1'b0, 9000);
    hold_lvl(1'b1, 4500);
    for (int i = 0; i < nbits; i++) begin
      hold_lvl(1'b0, 560);
      hold_lvl(1'b1, w[i] ? 1680 : 560);
    end
  endtask

  task automatic model_frame(input logic [7:0] a, an, c, cn);
    if (((a ^ an) == 8'hFF) && ((c ^ cn) == 8'hFF) && (a == 8'h00)) begin
      e_vld++;
      m_cmd  = c;
      m_addr = a;
      m_seen = 1'b1;
      for (int i = 0; i < 9; i++) if (keys[i] == c) m_sc = 4'(i);
    end else begin
      e_err++;
    end
  endtask

  task automatic send_frame(input logic [7:0] a, an, c, cn);
    send_word({cn, c, an, a}, 32);
    hold_lvl(1'b0, 560);
    hold_lvl(1'b1, 1000);
    model_frame(a, an, c, cn);
  endtask

  task automatic send_repeat();
    hold_lvl(1'b0, 9000);
    hold_lvl(1'b1, 2240);
    hold_lvl(1'b0, 560);
    hold_lvl(1'b1, 1000);
    if (m_seen) e_rpt++;
  endtask

  task automatic send_random_frame(input string tag);
    logic [7:0] c;
    if ($urandom_range(1, 0) == 1) c = keys[$urandom_range(8, 0)];
    else c = 8'($urandom);
    send_frame(8'h00, 8'hFF, c, ~c);
    check_all(tag);
  endtask

  initial begin
    rst = 1'b0;
    ir_in = 1'b1;
    repeat (5) @(negedge clk);
    check("reset state_control", state_control, 4'b0000);
    check("reset cmd", cmd, 8'h00);
    check("reset addr", addr, 8'h00);
    check("reset strobes/busy", {cmd_valid, repeat_pulse, frame_err, busy}, 4'b0000);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    send_repeat();
    check_all("repeat before frame");

    send_frame(8'h00, 8'hFF, 8'h18, 8'hE7);
    check_all("cmd 18");
    check("cmd 18 drive code", state_control, 4'b0100);

    send_frame(8'h00, 8'hFF, 8'h08, 8'hF6);
    check_all("bad checksum");

    send_frame(8'h00, 8'hFF, 8'h5A, 8'hA5);
    hold_lvl(1'b1, 39000);
    send_repeat();
    check_all("cmd 5A + repeat");
    check("cmd 5A drive code", state_control, 4'b0010);

    send_frame(8'h12, 8'hED, 8'h45, 8'hBA);
    check_all("address mismatch");

    send_random_frame("random frame 1");

    hold_lvl(1'b0, 6000);
    hold_lvl(1'b1, 2000);
    hold_lvl(1'b0, 15000);
    hold_lvl(1'b1, 1000);
    e_err += 2;
    check_all("short leader + stuck low");

    send_random_frame("random frame 2");

    send_word({8'hB8, 8'h47, 8'hFF, 8'h00}, 12);
    ir_in = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid-frame reset state_control", state_control, 4'b0000);
    check("mid-frame reset cmd/addr", {cmd, addr}, 16'h0000);
    check("mid-frame reset strobes/busy", {cmd_valid, repeat_pulse, frame_err, busy}, 4'b0000);
    ir_in = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    m_sc = 4'b0000;
    m_cmd = 8'h00;
    m_addr = 8'h00;
    m_seen = 1'b0;
    hold_lvl(1'b1, 2000);
    check_all("after reset release");

    send_frame(8'h00, 8'hFF, 8'h47, 8'hB8);
    check_all("cmd 47");
    check("cmd 47 drive code", state_control, 4'b0101);

    hold_lvl(1'b1, 145000);
    check("hold before 150 ms", state_control, 4'b0101);
    hold_lvl(1'b1, 6000);
`ifdef IR_HOLD_TIMEOUT_EN
    check("hold after 150 ms", state_control, 4'b0000);
`else
    check("hold after 150 ms", state_control, 4'b0101);
`endif
    check("cmd kept through hold", cmd, 8'h47);
    check("strobe exclusivity violations", n_multi, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
